// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I/RV32IM decode stage: opcode/funct constants,
// control enums and the decoded control bundle.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_IMM, OP1_ZERO} op1_src_e;
  typedef enum logic [2:0] {OP2_RS2, OP2_IMM, OP2_FOUR, OP2_TWELVE, OP2_UPPER_IMM} op2_src_e;
  typedef enum logic {PCSRC_PC, PCSRC_RS1} pc_src_e;
  typedef enum logic [1:0] {NPC_NOT_BRANCH, NPC_ALWAYS, NPC_ON_ZERO, NPC_ON_NOT_ZERO} next_pc_e;
  typedef enum logic {WB_ALU, WB_RAM} wb_src_e;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DOUBLE} mem_size_e;

  // imm and pc are width-parametrised, so they travel beside this bundle.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    op1_src_e   op1_src;
    op2_src_e   op2_src;
    pc_src_e    pc_op1_src;
    next_pc_e   next_pc;
    wb_src_e    wb_src;
    logic       reg_wr_en;
    logic       ram_wr_en;
    mem_size_e  mem_size;
    logic       mem_unsigned;
    logic       illegal;
  } decode_bundle_t;

  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e alu_muldiv(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: 32-bit instruction word to
// control bundle plus XLEN-wide immediate.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]     instr,
  output decode_bundle_t  bundle,
  output logic [XLEN-1:0] imm
);

  logic [6:0]      opcode, funct7, shift_hi;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;
  decode_bundle_t  nop, b;
  logic [XLEN-1:0] imm_sel;
  logic            ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  // At XLEN=64 bit 25 belongs to the shift amount, not to the funct7 check.
  assign shamt    = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign shift_hi = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];

  always_comb begin
    nop = '0;
    nop.rs1 = instr[19:15];
    nop.rs2 = instr[24:20];
    nop.rd  = instr[11:7];
    b       = nop;
    imm_sel = '0;
    ill     = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        b.op1_src   = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
        b.op2_src   = OP2_UPPER_IMM;
        b.reg_wr_en = 1'b1;
        imm_sel     = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        b.op1_src    = OP1_PC;
        b.op2_src    = OP2_FOUR;
        b.pc_op1_src = (opcode == OPC_JAL) ? PCSRC_PC : PCSRC_RS1;
        b.next_pc    = NPC_ALWAYS;
        b.reg_wr_en  = 1'b1;
        imm_sel      = (opcode == OPC_JAL) ? imm_j : imm_i;
      end
      OPC_BRANCH: begin
        imm_sel = imm_b;
        case (funct3)
          F3_BEQ:  begin b.alu_op = ALU_SUB;  b.next_pc = NPC_ON_ZERO;     end
          F3_BNE:  begin b.alu_op = ALU_SUB;  b.next_pc = NPC_ON_NOT_ZERO; end
          F3_BLT:  begin b.alu_op = ALU_SLT;  b.next_pc = NPC_ON_NOT_ZERO; end
          F3_BGE:  begin b.alu_op = ALU_SLT;  b.next_pc = NPC_ON_ZERO;     end
          F3_BLTU: begin b.alu_op = ALU_SLTU; b.next_pc = NPC_ON_NOT_ZERO; end
          F3_BGEU: begin b.alu_op = ALU_SLTU; b.next_pc = NPC_ON_ZERO;     end
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        b.op2_src      = OP2_IMM;
        b.wb_src       = WB_RAM;
        b.reg_wr_en    = 1'b1;
        b.mem_size     = mem_size_e'(funct3[1:0]);
        b.mem_unsigned = funct3[2];
        imm_sel        = imm_i;
        ill = (funct3 == 3'b111) || (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OPC_STORE: begin
        b.op2_src   = OP2_IMM;
        b.ram_wr_en = 1'b1;
        b.mem_size  = mem_size_e'(funct3[1:0]);
        imm_sel     = imm_s;
        ill = funct3[2] || (XLEN == 32 && funct3 == 3'b011);
      end
      OPC_OP_IMM: begin
        b.op2_src   = OP2_IMM;
        b.reg_wr_en = 1'b1;
        if (funct3 == F3_SLL) begin
          b.alu_op = ALU_SLL;
          imm_sel  = shamt;
          ill      = (shift_hi != F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          b.alu_op = (shift_hi == F7_ALT) ? ALU_SRA : ALU_SRL;
          imm_sel  = shamt;
          ill      = (shift_hi != F7_BASE) && (shift_hi != F7_ALT);
        end else begin
          b.alu_op = alu_base(funct3, 1'b0);
          imm_sel  = imm_i;
        end
      end
      OPC_OP: begin
        b.reg_wr_en = 1'b1;
        if (funct7 == F7_BASE)
          b.alu_op = alu_base(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))
          b.alu_op = alu_base(funct3, 1'b1);
        else if (funct7 == F7_MULDIV && ENABLE_M)
          b.alu_op = alu_muldiv(funct3);
        else
          ill = 1'b1;
      end
      OPC_MISC_MEM: ;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      b         = nop;
      b.illegal = 1'b1;
      imm_sel   = '0;
    end
    bundle = b;
    imm    = imm_sel;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry FIFO with valid/ready on
// both sides; outputs always present the head entry.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1_address,
  output logic [4:0]      rs2_address,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_rd_operator,
  output logic [1:0]      alu_rd_operand1_src,
  output logic [2:0]      alu_rd_operand2_src,
  output logic            alu_pc_operand1_src,
  output logic [1:0]      next_pc_src,
  output logic            reg_write_data_src,
  output logic            reg_wr_en,
  output logic            ram_wr_en,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic            illegal
);

  // Handshake: a transfer happens on a side exactly when its valid and ready
  // are both high at a rising clk edge; valid never depends on ready.
  decode_bundle_t  dec;
  decode_bundle_t  buf_ctl [2];
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] buf_imm [2];
  logic [PC_W-1:0] buf_pc  [2];
  logic [1:0]      count, count_next;
  logic            push, pop, push_to_head;

  decode_comb #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode_comb (
    .instr  (in_instr),
    .bundle (dec),
    .imm    (dec_imm)
  );

  assign out_valid    = (count != 2'd0);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign push_to_head = (count == 2'd0) || (count == 2'd1 && pop);
  assign count_next   = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        buf_ctl[i] <= '0;
        buf_imm[i] <= '0;
        buf_pc[i]  <= '0;
      end
    end else if (flush) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (pop) begin
        buf_ctl[0] <= buf_ctl[1];
        buf_imm[0] <= buf_imm[1];
        buf_pc[0]  <= buf_pc[1];
      end
      // A head write on push overrides the shift above (count 1, pop+push).
      if (push && push_to_head) begin
        buf_ctl[0] <= dec;
        buf_imm[0] <= dec_imm;
        buf_pc[0]  <= in_pc;
      end else if (push) begin
        buf_ctl[1] <= dec;
        buf_imm[1] <= dec_imm;
        buf_pc[1]  <= in_pc;
      end
    end
  end

  assign out_pc              = buf_pc[0];
  assign imm                 = buf_imm[0];
  assign rs1_address         = buf_ctl[0].rs1;
  assign rs2_address         = buf_ctl[0].rs2;
  assign rd_address          = buf_ctl[0].rd;
  assign alu_rd_operator     = buf_ctl[0].alu_op;
  assign alu_rd_operand1_src = buf_ctl[0].op1_src;
  assign alu_rd_operand2_src = buf_ctl[0].op2_src;
  assign alu_pc_operand1_src = buf_ctl[0].pc_op1_src;
  assign next_pc_src         = buf_ctl[0].next_pc;
  assign reg_write_data_src  = buf_ctl[0].wb_src;
  assign reg_wr_en           = buf_ctl[0].reg_wr_en;
  assign ram_wr_en           = buf_ctl[0].ram_wr_en;
  assign mem_size            = buf_ctl[0].mem_size;
  assign mem_unsigned        = buf_ctl[0].mem_unsigned;
  assign illegal             = buf_ctl[0].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure ordering,
// flush and mid-stream reset. A second instance runs with ENABLE_M=0.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, pc_op1, wb_src, reg_wr_en, ram_wr_en, mem_unsigned, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic [1:0]  op1_src, next_pc, mem_size;
  logic [2:0]  op2_src;

  logic        n_in_ready, n_out_valid, n_pc_op1, n_wb_src, n_reg_wr_en, n_ram_wr_en, n_mem_unsigned, n_illegal;
  logic [31:0] n_out_pc, n_imm;
  logic [4:0]  n_rs1, n_rs2, n_rd, n_alu_op;
  logic [1:0]  n_op1_src, n_next_pc, n_mem_size;
  logic [2:0]  n_op2_src;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1_address(rs1), .rs2_address(rs2), .rd_address(rd), .imm(imm),
    .alu_rd_operator(alu_op), .alu_rd_operand1_src(op1_src), .alu_rd_operand2_src(op2_src),
    .alu_pc_operand1_src(pc_op1), .next_pc_src(next_pc), .reg_write_data_src(wb_src),
    .reg_wr_en(reg_wr_en), .ram_wr_en(ram_wr_en), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .rs1_address(n_rs1), .rs2_address(n_rs2), .rd_address(n_rd), .imm(n_imm),
    .alu_rd_operator(n_alu_op), .alu_rd_operand1_src(n_op1_src), .alu_rd_operand2_src(n_op2_src),
    .alu_pc_operand1_src(n_pc_op1), .next_pc_src(n_next_pc), .reg_write_data_src(n_wb_src),
    .reg_wr_en(n_reg_wr_en), .ram_wr_en(n_ram_wr_en), .mem_size(n_mem_size),
    .mem_unsigned(n_mem_unsigned), .illegal(n_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Present one instruction for exactly one rising edge, then sample.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_pc"}, out_pc, 0);
    check({tag, "_imm"}, imm, 0);
    check({tag, "_alu_op"}, alu_op, ALU_ADD);
    check({tag, "_op2"}, op2_src, OP2_RS2);
    check({tag, "_reg_wr"}, reg_wr_en, 0);
    check({tag, "_ram_wr"}, ram_wr_en, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_next_pc"}, next_pc, NPC_NOT_BRANCH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic accepted;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    rst = 1'b0;
    out_ready = 1'b1;

    offer(32'h00500093, 32'h100);  // addi x1,x0,5
    check("addi_valid", out_valid, 1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 0);
    check("addi_imm", imm, 5);
    check("addi_op", alu_op, ALU_ADD);
    check("addi_op2", op2_src, OP2_IMM);
    check("addi_wr", reg_wr_en, 1);
    check("addi_illegal", illegal, 0);

    offer(32'h402081B3, 32'h104);  // sub x3,x1,x2
    check("sub_op", alu_op, ALU_SUB);
    check("sub_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
    check("sub_op2", op2_src, OP2_RS2);

    offer(32'h022081B3, 32'h108);  // mul x3,x1,x2
    check("mul_op", alu_op, ALU_MUL);
    check("mul_illegal", illegal, 0);
    check("nom_mul_illegal", n_illegal, 1);
    check("nom_mul_wr", n_reg_wr_en, 0);
    check("nom_mul_rd", n_rd, 3);

    offer(32'hFE208EE3, 32'h10C);  // beq x1,x2,-4
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_op", alu_op, ALU_SUB);
    check("beq_next_pc", next_pc, NPC_ON_ZERO);
    check("beq_pc_op1", pc_op1, PCSRC_PC);
    check("beq_wr", reg_wr_en, 0);

    offer(32'hFFFFFFFF, 32'h110);
    check("ones_illegal", illegal, 1);
    check("ones_wr", {reg_wr_en, ram_wr_en}, 0);
    check("ones_next_pc", next_pc, NPC_NOT_BRANCH);
    check("ones_rd", rd, 5'd31);

    offer(32'h0040A183, 32'h114);  // lw x3,4(x1)
    check("lw_size", mem_size, MEM_WORD);
    check("lw_unsigned", mem_unsigned, 0);
    check("lw_wb", wb_src, WB_RAM);
    check("lw_imm", imm, 4);

    offer(32'h123452B7, 32'h118);  // lui x5,0x12345
    check("lui_imm", imm, 32'h12345000);
    check("lui_srcs", {op1_src, op2_src}, {OP1_ZERO, OP2_UPPER_IMM});

    offer(32'h4030D093, 32'h11C);  // srai x1,x1,3
    check("srai_op", alu_op, ALU_SRA);
    check("srai_imm", imm, 3);

    offer(32'h00003083, 32'h120);  // ld on RV32: illegal
    check("ld32_illegal", illegal, 1);
    offer(32'h00002063, 32'h124);  // branch funct3 010: illegal
    check("br010_illegal", illegal, 1);
    @(posedge clk); #1;
    check("drained_valid", out_valid, 0);

    // Backpressure: I0, I1 fill the buffer, I2 is held until space frees.
    out_ready = 1'b0;
    offer(32'h00100093, 32'h200);
    offer(32'h00200113, 32'h204);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;
    check("full_in_ready", in_ready, 0);
    check("full_head_pc", out_pc, 32'h200);
    @(posedge clk); #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_head_pc", out_pc, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid) check("order_pc", out_pc, exp_q.pop_front());
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    check("order_left", exp_q.size(), 0);
    check("order_done_valid", out_valid, 0);

    // Flush with two entries buffered, then with one plus an acceptable offer.
    out_ready = 1'b0;
    offer(32'h00500293, 32'h300);
    offer(32'h00600313, 32'h304);
    flush = 1'b1;
    offer(32'h00700393, 32'h308);
    flush = 1'b0;
    check("flush2_valid", out_valid, 0);
    check("flush2_in_ready", in_ready, 1);
    offer(32'h00500293, 32'h310);
    flush = 1'b1;
    offer(32'h00600313, 32'h314);
    flush = 1'b0;
    check("flush1_valid", out_valid, 0);
    out_ready = 1'b1;
    offer(32'h00700393, 32'h320);
    check("post_flush_pc", out_pc, 32'h320);
    check("post_flush_rd", rd, 7);
    @(posedge clk); #1;
    check("post_flush_drained", out_valid, 0);

    // Reset mid-stream with two entries buffered and an offer pending.
    out_ready = 1'b0;
    offer(32'h123452B7, 32'h400);
    offer(32'hFE208EE3, 32'h404);
    rst = 1'b1;
    offer(32'h00500093, 32'h408);
    rst = 1'b0;
    check_idle_reset("midrst");
    check("midrst_rd", rd, 0);
    check("midrst_op1", op1_src, OP1_RS1);
    @(posedge clk); #1;
    check("midrst_still_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
